// File: rtl/arm_control_unit.sv
// rtl/arm_control_unit.sv - Control unit for the single-cycle ARM-subset datapath
//
// Main decoder, ALU decoder and conditional logic for the single-cycle
// datapath. Instruction fields are decoded combinationally into datapath
// selects and write enables. The NZCV flag register is held here, and every
// architectural write enable is gated by the condition check of the current
// instruction.
//
// Optional feature macro: CU_CMP_EN
//   defined   : cmd 1010 (CMP) subtracts, always writes all flags and never
//               writes the register file.
//   undefined : cmd 1010 decodes like any unlisted cmd.
//
// Ports
//   clk        in   1  flag register clock (rising edge)
//   reset      in   1  asynchronous active-high, clears NZCV
//   Cond       in   4  instr[31:28] condition code
//   ALUFlags   in   4  {N,Z,C,V} produced by the ALU for this instruction
//   Op         in   2  instr[27:26]
//   Funct      in   6  instr[25:20]: [5]=I, [4:1]=cmd, [0]=S or L
//   Rd         in   4  instr[15:12]
//   MemToReg   out  1  writeback from data memory
//   ALUControl out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
//   ALUSrc     out  1  immediate as ALU operand B
//   ImmSrc     out  2  00 imm8 rot, 01 imm12, 10 imm24 branch
//   RegSrc     out  2  [0] PC as Rn, [1] Rd as Rm
//   PCSrc      out  1  PC loaded from result
//   RegWrite   out  1  register file write enable
//   MemWrite   out  1  data memory write enable

module arm_control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       MemToReg,
    output logic [1:0] ALUControl,
    output logic       ALUSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite
);

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    logic       funct_i;
    logic [3:0] funct_cmd;
    logic       funct_s;

    assign funct_i   = Funct[5];
    assign funct_cmd = Funct[4:1];
    assign funct_s   = Funct[0];

    // Main decoder outputs
    logic       regw_main;
    logic       memw;
    logic       memtoreg_d;
    logic       alusrc_d;
    logic [1:0] immsrc_d;
    logic [1:0] regsrc_d;
    logic       branch;
    logic       aluop;

    always_comb begin
        regw_main  = 1'b0;
        memw       = 1'b0;
        memtoreg_d = 1'b0;
        alusrc_d   = 1'b0;
        immsrc_d   = 2'b00;
        regsrc_d   = 2'b00;
        branch     = 1'b0;
        aluop      = 1'b0;
        case (Op)
            OP_DP: begin
                regw_main = 1'b1;
                alusrc_d  = funct_i;
                aluop     = 1'b1;
            end
            OP_MEM: begin
                alusrc_d = 1'b1;
                immsrc_d = 2'b01;
                if (funct_s) begin
                    // LDR
                    regw_main  = 1'b1;
                    memtoreg_d = 1'b1;
                end else begin
                    // STR reads the store data through the Rm port
                    memw     = 1'b1;
                    regsrc_d = 2'b10;
                end
            end
            OP_BR: begin
                alusrc_d = 1'b1;
                immsrc_d = 2'b10;
                regsrc_d = 2'b01;
                branch   = 1'b1;
            end
            default: begin
                // Op=11 is treated as a no-op: nothing is written
            end
        endcase
    end

    // ALU decoder
    logic [1:0] alucontrol_d;
    logic [1:0] flagw;
    logic       cmp_kill;

    always_comb begin
        alucontrol_d = ALU_ADD;
        flagw        = 2'b00;
        cmp_kill     = 1'b0;
        if (aluop) begin
            case (funct_cmd)
                CMD_ADD: alucontrol_d = ALU_ADD;
                CMD_SUB: alucontrol_d = ALU_SUB;
                CMD_AND: alucontrol_d = ALU_AND;
                CMD_ORR: alucontrol_d = ALU_ORR;
                default: alucontrol_d = ALU_ADD;
            endcase
            // Logical ops leave C and V alone
            flagw[1] = funct_s;
            flagw[0] = funct_s &
                       ((alucontrol_d == ALU_ADD) || (alucontrol_d == ALU_SUB));
`ifdef CU_CMP_EN
            if (funct_cmd == CMD_CMP) begin
                alucontrol_d = ALU_SUB;
                flagw        = 2'b11;
                cmp_kill     = 1'b1;
            end
`endif
        end
    end

    logic regw;
    logic pcs;

    assign regw = regw_main & ~cmp_kill;
    // Any register write to R15 is a jump
    assign pcs  = (regw & (Rd == 4'hF)) | branch;

    // Flag register and condition check
    logic [3:0] nzcv;
    logic       flag_n, flag_z, flag_c, flag_v;
    logic       condex;

    assign {flag_n, flag_z, flag_c, flag_v} = nzcv;

    always_comb begin
        condex = 1'b0;
        case (Cond)
            4'h0: condex = flag_z;
            4'h1: condex = ~flag_z;
            4'h2: condex = flag_c;
            4'h3: condex = ~flag_c;
            4'h4: condex = flag_n;
            4'h5: condex = ~flag_n;
            4'h6: condex = flag_v;
            4'h7: condex = ~flag_v;
            4'h8: condex = flag_c & ~flag_z;
            4'h9: condex = ~flag_c | flag_z;
            4'hA: condex = (flag_n == flag_v);
            4'hB: condex = (flag_n != flag_v);
            4'hC: condex = ~flag_z & (flag_n == flag_v);
            4'hD: condex = flag_z | (flag_n != flag_v);
            4'hE: condex = 1'b1;
            default: condex = 1'b0; // unconditional-extension space disabled
        endcase
    end

    // Flags are only visible to the condition check from the next cycle on
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nzcv <= 4'b0000;
        end else begin
            if (flagw[1] & condex)
                nzcv[3:2] <= ALUFlags[3:2];
            if (flagw[0] & condex)
                nzcv[1:0] <= ALUFlags[1:0];
        end
    end

    assign MemToReg   = memtoreg_d;
    assign ALUControl = alucontrol_d;
    assign ALUSrc     = alusrc_d;
    assign ImmSrc     = immsrc_d;
    assign RegSrc     = regsrc_d;
    assign PCSrc      = pcs & condex;
    assign RegWrite   = regw & condex;
    assign MemWrite   = memw & condex;

endmodule

// File: tb/tb_arm_control_unit.sv
// tb/tb_arm_control_unit.sv - Directed self-checking bench for arm_control_unit

module tb_arm_control_unit;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       MemToReg;
    logic [1:0] ALUControl;
    logic       ALUSrc;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;

    int n_checks;
    int n_fail;

    arm_control_unit dut (
        .clk       (clk),
        .reset     (reset),
        .Cond      (Cond),
        .ALUFlags  (ALUFlags),
        .Op        (Op),
        .Funct     (Funct),
        .Rd        (Rd),
        .MemToReg  (MemToReg),
        .ALUControl(ALUControl),
        .ALUSrc    (ALUSrc),
        .ImmSrc    (ImmSrc),
        .RegSrc    (RegSrc),
        .PCSrc     (PCSrc),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] actual,
                            input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Present an instruction word and ALU flags, then let decode settle
    task automatic drive(input logic [31:0] instr, input logic [3:0] flags);
        Cond     = instr[31:28];
        Op       = instr[27:26];
        Funct    = instr[25:20];
        Rd       = instr[15:12];
        ALUFlags = flags;
        #1;
    endtask

    // One rising edge; inputs are changed again only after the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic exp_cond [16];
    logic [31:0] br;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        drive(32'h0, 4'h0);
        @(negedge clk);

        // STR with AL while in reset
        drive(32'hE4813004, 4'h0);
        check_eq("str_memwrite", MemWrite, 1);
        check_eq("str_regwrite", RegWrite, 0);
        check_eq("str_alusrc",   ALUSrc,   1);
        check_eq("str_immsrc",   ImmSrc,   2'b01);
        check_eq("str_regsrc",   RegSrc,   2'b10);
        check_eq("str_pcsrc",    PCSrc,    0);

        // MOV-like DP immediate, cmd 1101
        drive(32'hE3A01000, 4'h0);
        check_eq("dpi_regwrite", RegWrite,   1);
        check_eq("dpi_alusrc",   ALUSrc,     1);
        check_eq("dpi_immsrc",   ImmSrc,     2'b00);
        check_eq("dpi_aluctl",   ALUControl, 2'b00);
        check_eq("dpi_memwrite", MemWrite,   0);

        // Reset flags: EQ false, NE true, cond F never
        drive(32'h0A000002, 4'h0);
        check_eq("rst_beq_pcsrc", PCSrc, 0);
        drive(32'h1A000002, 4'h0);
        check_eq("rst_bne_pcsrc", PCSrc, 1);
        drive(32'hFA000002, 4'h0);
        check_eq("condf_pcsrc", PCSrc, 0);

        reset = 1'b0;
        @(negedge clk);

        // SUBSEQ fails its condition: no write, no flag update
        drive(32'h02522001, 4'b0100);
        check_eq("subseq_regwrite", RegWrite, 0);
        step();
        drive(32'h0A000002, 4'h0);
        check_eq("subseq_noflag_beq", PCSrc, 0);

        // SUBS sets Z
        drive(32'hE2522001, 4'b0100);
        check_eq("subs_aluctl",   ALUControl, 2'b01);
        check_eq("subs_regwrite", RegWrite,   1);
        step();
        drive(32'h0A000002, 4'h0);
        check_eq("beq_pcsrc",    PCSrc,    1);
        check_eq("beq_immsrc",   ImmSrc,   2'b10);
        check_eq("beq_regsrc",   RegSrc,   2'b01);
        check_eq("beq_alusrc",   ALUSrc,   1);
        check_eq("beq_regwrite", RegWrite, 0);

        // ADD without S leaves Z set
        drive(32'hE0810002, 4'b0000);
        check_eq("add_aluctl", ALUControl, 2'b00);
        step();
        drive(32'h0A000002, 4'h0);
        check_eq("add_keeps_flags", PCSrc, 1);

        drive(32'hE0012002, 4'h0);
        check_eq("and_aluctl", ALUControl, 2'b10);
        check_eq("and_alusrc", ALUSrc,     0);
        drive(32'hE1812002, 4'h0);
        check_eq("orr_aluctl", ALUControl, 2'b11);

        // SUBS sets C only; ANDS then clears NZ but must keep C
        drive(32'hE2522001, 4'b0010);
        step();
        drive(32'hE0112002, 4'b0000);
        step();
        drive(32'h2A000002, 4'h0);
        check_eq("ands_keeps_c", PCSrc, 1);
        drive(32'h0A000002, 4'h0);
        check_eq("ands_clears_z", PCSrc, 0);

        // Condition table with NZCV = 1001
        drive(32'hE2522001, 4'b1001);
        step();
        exp_cond = '{0,1,0,1,1,0,1,0,0,1,1,0,1,0,1,0};
        for (int i = 0; i < 16; i++) begin
            br = 32'h0A000002;
            br[31:28] = 4'(i);
            drive(br, 4'h0);
            check_eq($sformatf("cond_%0h", i), PCSrc, exp_cond[i]);
        end

        // LDR into PC
        drive(32'hE591F000, 4'h0);
        check_eq("ldrpc_regwrite", RegWrite, 1);
        check_eq("ldrpc_memtoreg", MemToReg, 1);
        check_eq("ldrpc_pcsrc",    PCSrc,    1);

        // Op=11 no-op
        drive(32'hEC00F000, 4'h0);
        check_eq("op3_regwrite", RegWrite, 0);
        check_eq("op3_memwrite", MemWrite, 0);
        check_eq("op3_pcsrc",    PCSrc,    0);
        check_eq("op3_memtoreg", MemToReg, 0);

        // CMP r2, r3
        drive(32'hE1520003, 4'h0);
`ifdef CU_CMP_EN
        check_eq("cmp_aluctl",   ALUControl, 2'b01);
        check_eq("cmp_regwrite", RegWrite,   0);
`else
        check_eq("cmp_aluctl",   ALUControl, 2'b00);
        check_eq("cmp_regwrite", RegWrite,   1);
`endif

        // Asynchronous reset mid-cycle clears N without a clock edge
        drive(32'h4A000002, 4'h0);
        check_eq("mi_before_reset", PCSrc, 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("mi_after_async_reset", PCSrc, 0);
        drive(32'hEA000002, 4'h0);
        check_eq("al_in_reset", PCSrc, 1);
        @(negedge clk);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
